// File: rtl/instr_fetch_pkg.sv
// Shared pipeline definitions for the fetch stage: state encoding,
// PC increment constant and the hold-buffer entry layout.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        SQUASH = 2'd1,
        HOLD   = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_INC = 32'h4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Sequential PC; wraps modulo 2^32.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry hold buffer for a fetched word decode could not accept.
// Ports: CLK/RESET, load/unload/flush controls, din entry in,
// dout entry out, full flag.
module fetch_skid_buffer
    import instr_fetch_pkg::*;
(
    input  logic         CLK,
    input  logic         RESET,
    input  logic         load,
    input  logic         unload,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic         full
);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            full <= 1'b0;
            dout <= '0;
        end else begin
            // flush wins over load so a redirect never leaves a stale word
            if (flush || unload) begin
                full <= 1'b0;
            end else if (load) begin
                full <= 1'b1;
            end
            if (load && !flush) begin
                dout <= din;
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues I-cache reads, handles redirects,
// squashes stale responses and holds a word while decode is frozen.
// Ports: CLK/RESET; decode side Request_Alt_PC, Alt_PC, WANT_FREEZE;
// I-cache side Instr_address_2IC, ReadRequest_2IC, Instr_fIC,
// Instr_valid_fIC, STALL_fICache; decode outputs Instr1_OUT,
// Instr_PC_OUT, Instr_PC_Plus4_OUT (all zero = bubble).
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        Request_Alt_PC,
    input  logic [31:0] Alt_PC,
    input  logic        WANT_FREEZE,
    output logic [31:0] Instr_address_2IC,
    output logic        ReadRequest_2IC,
    input  logic [31:0] Instr_fIC,
    input  logic        Instr_valid_fIC,
    output logic        STALL_fICache,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr_PC_OUT,
    output logic [31:0] Instr_PC_Plus4_OUT
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  sq_addr_q;
    logic         req_en_q;
    logic         got;
    logic         take_new;
    logic         load_buf;
    logic         take_buf;
    fetch_entry_t buf_din;
    fetch_entry_t buf_dout;
    logic         buf_full;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH: begin
                if (Request_Alt_PC) begin
                    // an unanswered request must be drained first
                    state_d = STALL_fICache ? SQUASH : FETCH;
                end else if (got && WANT_FREEZE) begin
                    state_d = HOLD;
                end
            end
            SQUASH: begin
                // the stale response retires the old request
                if (Instr_valid_fIC) begin
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (Request_Alt_PC || !WANT_FREEZE) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        // no request in the first cycle after reset release
        ReadRequest_2IC   = req_en_q &&
                            (state_q == FETCH || state_q == SQUASH);
        Instr_address_2IC = (state_q == SQUASH) ? sq_addr_q : pc_q;
        STALL_fICache     = ReadRequest_2IC && !Instr_valid_fIC;
        got               = ReadRequest_2IC && Instr_valid_fIC &&
                            (state_q == FETCH);
        take_new          = got && !Request_Alt_PC && !WANT_FREEZE;
        load_buf          = got && !Request_Alt_PC && WANT_FREEZE;
        take_buf          = (state_q == HOLD) && buf_full &&
                            !Request_Alt_PC && !WANT_FREEZE;
        if (Request_Alt_PC) begin
            pc_d = Alt_PC;
        end else if (got) begin
            pc_d = pc_next(pc_q);
        end else begin
            pc_d = pc_q;
        end
    end

    assign buf_din = '{instr: Instr_fIC, pc: pc_q};

    fetch_skid_buffer u_skid (
        .CLK    (CLK),
        .RESET  (RESET),
        .load   (load_buf),
        .unload (take_buf),
        .flush  (Request_Alt_PC),
        .din    (buf_din),
        .dout   (buf_dout),
        .full   (buf_full)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc_q               <= RESET_PC;
            sq_addr_q          <= RESET_PC;
            req_en_q           <= 1'b0;
            Instr1_OUT         <= '0;
            Instr_PC_OUT       <= '0;
            Instr_PC_Plus4_OUT <= '0;
        end else begin
            pc_q      <= pc_d;
            // tracks the live address; frozen while squashing
            sq_addr_q <= Instr_address_2IC;
            req_en_q  <= 1'b1;
            if (take_new) begin
                Instr1_OUT         <= Instr_fIC;
                Instr_PC_OUT       <= pc_q;
                Instr_PC_Plus4_OUT <= pc_next(pc_q);
            end else if (take_buf) begin
                Instr1_OUT         <= buf_dout.instr;
                Instr_PC_OUT       <= buf_dout.pc;
                Instr_PC_Plus4_OUT <= pc_next(buf_dout.pc);
            end else if (!WANT_FREEZE) begin
                Instr1_OUT         <= '0;
                Instr_PC_OUT       <= '0;
                Instr_PC_Plus4_OUT <= '0;
            end
        end
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 CLK  in  1  clock; all state on rising edge.
REQ-004 RESET  in  1  asynchronous active-low reset.
REQ-005 Request_Alt_PC  in  1  redirect request from decode.
REQ-006 Alt_PC  in  32  redirect target from decode.
REQ-007 WANT_FREEZE  in  1  decode cannot accept a new instruction this cycle.
REQ-008 Instr_address_2IC  out  32  fetch address to I-cache.
REQ-009 ReadRequest_2IC  out  1  fetch request valid.
REQ-010 Instr_fIC  in  32  instruction word from I-cache.
REQ-011 Instr_valid_fIC  in  1  Instr_fIC answers the outstanding request.
REQ-012 STALL_fICache  out  1  request outstanding and no response this cycle.
REQ-013 Instr1_OUT  out  32  instruction to decode (0 = bubble).
REQ-014 Instr_PC_OUT  out  32  PC of Instr1_OUT.
REQ-015 Instr_PC_Plus4_OUT  out  32  Instr_PC_OUT+4.

Function
REQ-016 States SHALL be FETCH, SQUASH and HOLD; reset enters FETCH.
REQ-017 PC SHALL be a 32-bit register; PC+4 wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-018 In FETCH, ReadRequest_2IC=1 and Instr_address_2IC=PC; the address SHALL stay stable until Instr_valid_fIC.
REQ-019 STALL_fICache SHALL be combinational: ReadRequest_2IC & !Instr_valid_fIC.
REQ-020 FETCH, valid, !WANT_FREEZE, no redirect: register Instr_fIC/PC/PC+4 to outputs; PC<=PC+4; stay FETCH (1-cycle latency, back-to-back fetch allowed).
REQ-021 FETCH, valid, WANT_FREEZE, no redirect: capture word and PC in 1-entry hold buffer; outputs unchanged; PC<=PC+4; go HOLD.
REQ-022 HOLD: ReadRequest_2IC=0; outputs unchanged while WANT_FREEZE; when !WANT_FREEZE, deliver buffer to outputs and return to FETCH.
REQ-023 Cycles with nothing delivered and !WANT_FREEZE: Instr1_OUT, Instr_PC_OUT and Instr_PC_Plus4_OUT SHALL be 0 (bubble); with WANT_FREEZE, outputs hold.
REQ-024 Redirect (Request_Alt_PC=1) SHALL take priority over WANT_FREEZE and delivery: PC<=Alt_PC; hold buffer and any same-cycle response discarded; outputs <=0 unless WANT_FREEZE.
REQ-025 Redirect in FETCH with request outstanding and no valid: go SQUASH; SQUASH keeps ReadRequest_2IC=1 at the old address and discards its response, then returns to FETCH at Alt_PC.
REQ-026 Redirect in SQUASH SHALL update PC to the newer Alt_PC and remain in SQUASH.
REQ-027 Redirect in HOLD, or in FETCH with Instr_valid_fIC=1, SHALL go directly to FETCH at Alt_PC.
REQ-028 Alt_PC SHALL be used unaligned-as-given; no alignment check.
REQ-029 An instruction SHALL never be delivered twice or skipped absent redirect.

Reset
REQ-030 RESET low SHALL immediately set PC=RESET_PC, state=FETCH, outputs 0, hold buffer empty, ReadRequest_2IC low until first edge after release.
REQ-031 Reset mid-request SHALL drop the request; the first post-reset response belongs to the RESET_PC request.

Structure
REQ-032 State encoding (FETCH/SQUASH/HOLD) and the 32'h4 increment constant SHALL live in the shared pipeline package alongside config.v defines.
REQ-033 The hold buffer SHALL be a sub-module fetch_skid_buffer (1 entry, load/unload/flush); everything else flat.

Verification
REQ-034 Reset release, I-cache always valid, RESET_PC=0 -> Instr_PC_OUT 0,4,8,... one per cycle, Instr1_OUT = memory words.
REQ-035 Cache valid delayed 3 cycles at PC=0x10 -> STALL_fICache=1 for 3 cycles, bubbles, then 0x10 delivered once.
REQ-036 WANT_FREEZE high 2 cycles as 0x20 returns -> outputs hold prior instr, 0x20 delivered on first unfrozen cycle, PC=0x24, no duplicates.
REQ-037 Redirect to 0x400 while 0x30 outstanding -> late 0x30 response discarded, next delivered Instr_PC_OUT=0x400.
REQ-038 Redirect in HOLD -> held word never delivered; next PC 0x400; redirect with WANT_FREEZE high -> PC still updated.
REQ-039 PC=0xFFFF_FFFC fetched -> Instr_PC_Plus4_OUT=0, next fetch address 0; RESET pulsed mid-request -> outputs 0, restart at RESET_PC.
